// File: rtl/mdu.sv
// mdu - multiply/divide unit for the E stage.
//
// Runs mult/multu/div/divu with a fixed multi-cycle latency, holds the
// architectural HI/LO registers and serves mfhi/mflo/mthi/mtlo. The result
// is computed at the accepting edge and parked in hi_p/lo_p; busy then
// stays high for MULT_CYCLES or DIV_CYCLES before HI/LO are committed.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, clears all state
//   start  - E-stage instruction is mult/multu/div/divu
//   op     - 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//   req    - E-stage instruction cancelled; blocks start/mthi/mtlo
//   A, B   - forwarded rs/rt operands
//   busy   - multi-cycle operation in progress (registered)
//   HI, LO - architectural HI/LO
//   out    - combinational mfhi/mflo read, 0 for other ops
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  // 64-bit product; operands are sign- or zero-extended so the low 64 bits
  // of the signed multiply are correct for both flavours.
  function automatic logic [63:0] mul64(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    p  = sa * sb;
    return p;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of
  // overflowing; quotient truncates toward zero, remainder takes A's sign.
  // B == 0 yields zeros (the commit is suppressed anyway).
  function automatic logic [63:0] div64(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        neg_q;
    logic        neg_r;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    neg_q = sgn & (a[31] ^ b[31]);
    neg_r = sgn & a[31];
    ma    = neg_r ? -a : a;
    mb    = (sgn & b[31]) ? -b : b;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (neg_q) q = -q;
    if (neg_r) r = -r;
    return {r, q};
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      hi_p, hi_p_n;
  logic [31:0]      lo_p, lo_p_n;
  logic             dz, dz_n;
  logic [31:0]      hi_n, lo_n;

  logic             is_md;
  logic             is_div;
  logic             sgn;
  logic [63:0]      res;

  assign is_md  = (op >= OP_MULT) && (op <= OP_DIVU);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign res    = is_div ? div64(sgn, A, B) : mul64(sgn, A, B);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_p  <= '0;
      lo_p  <= '0;
      dz    <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_p  <= hi_p_n;
      lo_p  <= lo_p_n;
      dz    <= dz_n;
      HI    <= hi_n;
      LO    <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_p_n  = hi_p;
    lo_p_n  = lo_p;
    dz_n    = dz;
    hi_n    = HI;
    lo_n    = LO;
    case (state)
      IDLE: begin
        if (!req) begin
          if (start && is_md) begin
            state_n          = RUN;
            cnt_n            = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            {hi_p_n, lo_p_n} = res;
            dz_n             = is_div && (B == 32'd0);
          end else if (op == OP_MTHI) begin
            hi_n = A;
          end else if (op == OP_MTLO) begin
            lo_n = A;
          end
        end
      end
      RUN: begin
        // Inputs are ignored here: the hazard unit keeps md-class
        // instructions out of E while busy, and req cannot abort.
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          if (!dz) begin
            hi_n = hi_p;
            lo_n = lo_p;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_comb begin
    case (op)
      OP_MFHI: out = HI;
      OP_MFLO: out = LO;
      default: out = 32'd0;
    endcase
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the five-stage pipeline. Executes mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO registers. Serves mfhi/mflo/mthi/mtlo. Drives the `busy` handshake that the D-stage hazard unit uses to stall any following multiply/divide-class instruction. This block is the producer of that stall condition; the hazard unit is its consumer.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: E-stage instruction is mult/multu/div/divu; qualifies `op` 1–4.
- `op` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; others treated as none.
- `req` input 1: the E-stage instruction is being cancelled (exception/interrupt). When high, `start`, mthi and mtlo are ignored.
- `A` input 32: rs operand, already forwarded.
- `B` input 32: rt operand, already forwarded.
- `busy` output 1: a multi-cycle operation is in progress.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.
- `out` output 32: combinational read. HI when `op`=5, LO when `op`=6, else 0.

## Operation
- State is IDLE or RUN; a down-counter `cnt`; pending results `hi_p`/`lo_p`.
- Accepted start: in IDLE, with `start`=1, `req`=0 and `op` in 1–4, at a clock edge.
  - Latch `cnt` = MULT_CYCLES (op 1, 2) or DIV_CYCLES (op 3, 4).
  - Compute and latch `hi_p`/`lo_p` from A and B at that edge; go to RUN.
- mult: signed 64-bit product; `{hi_p, lo_p}` = A*B.
- multu: unsigned 64-bit product.
- div: signed division; `lo_p` = quotient truncated toward zero; `hi_p` = remainder, with the sign of A.
  - A=0x80000000, B=0xFFFFFFFF gives lo_p=0x80000000, hi_p=0.
- divu: unsigned division; lo_p = A/B, hi_p = A%B.
- Division by zero (B=0): the operation still runs for DIV_CYCLES with `busy` asserted. HI and LO are left unchanged at completion; no X ever reaches HI/LO.
- RUN: `cnt` decrements each edge. On the edge where `cnt` goes 1→0:
  - HI←hi_p, LO←lo_p (except divide by zero);
  - return to IDLE.
- `busy` = (state == RUN), driven from a register, not from inputs.
- mthi (`op`=7): HI←A at the edge, in IDLE with `req`=0. mtlo (`op`=8) does the same for LO. Each takes one cycle and does not assert `busy`.
- Any `start`/mthi/mtlo arriving while `busy`=1 is ignored. The hazard unit guarantees none arrive; the bench flags one as an error.
- `req`=1 during RUN has no effect; the accepted operation completes.
- mfhi/mflo read the current HI/LO through `out`. While busy, they return the old values; the hazard unit stalls them.
- Reset at any time: state IDLE, cnt=0, busy=0, HI=0, LO=0, hi_p=lo_p=0. An in-flight operation is discarded.

## Timing
- Start accepted at edge t. `busy`=1 in cycles t+1 … t+N, where N is MULT_CYCLES or DIV_CYCLES.
- New HI/LO are visible in cycle t+N+1, the first cycle with `busy`=0.
- Back-to-back: a new `start` is accepted at the edge ending cycle t+N+1 at the earliest. There is no same-edge restart on completion.
- Hazard contract: the stall unit stalls a D-stage md-class instruction (mult…mtlo, mfhi, mflo) whenever `busy`=1 or the E stage has `start`=1.
- `out` is purely combinational from `op`, HI and LO; zero cycles latency.
- Operands are sampled only at the accepting edge. Later changes of A/B during RUN do not affect the result.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2), B=3:
  - busy high for exactly 5 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFA;
  - mfhi/mflo `out` match.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div with A=−7 (0xFFFFFFF9), B=2: busy for 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- divu with B=0 after mthi 0x1234 / mtlo 0x5678: busy for 10 cycles; HI=0x1234 and LO=0x5678 unchanged.
- start with `req`=1: busy stays 0 and HI/LO are unchanged. Then start a div, and at cycle t+4 change A/B and pulse req and start: result reflects the original operands at cycle t+11.
- Assert reset asynchronously mid-div at cycle t+3: busy, HI and LO drop to 0 immediately, without waiting for a clock edge. The next mtlo 0xABCD gives LO=0xABCD one cycle later.
